pulse_stretcher: RTL

//  Turns single-cycle trigger pulses (edge-detector output) back into a timed

---
 rtl/pnu_pkg.sv | 8 +
 rtl/pulse_stretcher_cnt.sv | 38 +++
 rtl/pulse_stretcher.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pnu_pkg.sv
// Shared state encoding for the pulse stretcher.
package pnu_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

endpackage

// File: rtl/pulse_stretcher_cnt.sv
// Loadable down-counter. Load wins over decrement; it saturates at zero.
module pulse_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          is_one_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: load has priority, decrement never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign is_one_o = (cnt_q == CW'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into a len-cycle high level, then holds off
// for gap cycles before another trigger can be accepted.
module pulse_stretcher #(
    parameter int unsigned CW     = 8,
    parameter bit          RETRIG = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trigger,
    input  logic [CW-1:0] len,
    input  logic [CW-1:0] gap,
    output logic          sig_out,
    output logic          busy,
    output logic          drop
);
    import pnu_pkg::*;

    logic [1:0]    state_q, state_d;
    logic          sig_q, sig_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic [CW-1:0] cnt_val;
    logic          cnt_is_one;

    pulse_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .is_one_o   (cnt_is_one)
    );

    // Next-state, counter control and registered-output next values.
    always_comb begin
        state_d      = state_q;
        sig_d        = sig_q;
        busy_d       = busy_q;
        drop_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = len;
        cnt_dec      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger && (len != '0)) begin
                    state_d  = ST_ACTIVE;
                    cnt_load = 1'b1;
                    sig_d    = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (RETRIG && trigger && (len != '0)) begin
                    // Extend: reload with the current len, stay high.
                    cnt_load = 1'b1;
                end else begin
                    if (!RETRIG && trigger) begin
                        drop_d = 1'b1;
                    end
                    // Decrement also on exit so the counter rests at zero in IDLE.
                    cnt_dec = 1'b1;
                    if (cnt_is_one) begin
                        sig_d = 1'b0;
                        if (gap != '0) begin
                            state_d      = ST_HOLDOFF;
                            cnt_load     = 1'b1;
                            cnt_load_val = gap;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            ST_HOLDOFF: begin
                sig_d   = 1'b0;
                cnt_dec = 1'b1;
                if (trigger) begin
                    drop_d = 1'b1;
                end
                if (cnt_is_one) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sig_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any pulse in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign sig_out = sig_q;
    assign busy    = busy_q;
    assign drop    = drop_q;

endmodule
